// File: rtl/sad_load_ctrl.sv
// sad_load_ctrl
// Sequences one motion-search pass: loads the reference block once into its
// serial buffer, then for each of CAND_NUM candidate blocks clears and loads
// the candidate buffer, kicks the SAD unit and keeps the lowest SAD result
// together with the index of the candidate that produced it.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, abort        search request pulse / cancel a running search
//   ref_addr            reference block base address
//   cand_addr           first candidate base address
//   cand_stride         address step between candidates
//   mem_rd_en, mem_addr memory read strobe and address
//   mem_rd_data         read data, valid one cycle after mem_rd_en
//   buf_data            pixel forwarded to the serial buffers
//   ref_wr_en/cand_wr_en   buffer write strobes
//   ref_buf_rst/cand_buf_rst  buffer clear pulses (active high)
//   ref_buf_full/cand_buf_full buffer full flags
//   sad_start, sad_done, sad_value   SAD unit handshake and result
//   busy, done          search in progress / one-cycle completion pulse
//   best_sad, best_idx  minimum SAD and its candidate index
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// CLR_REF   | clear both buffers (once per search)
// LOAD_REF  | stream BUF_SIZE reference pixels from memory
// WAIT_REF  | wait for the reference buffer to report full
// CLR_CAND  | clear the candidate buffer
// LOAD_CAND | stream BUF_SIZE candidate pixels from memory
// WAIT_CAND | wait for the candidate buffer to report full
// SAD_GO    | pulse sad_start
// WAIT_SAD  | wait for sad_done, capture sad_value
// UPDATE    | compare against best, step to next candidate or finish
// FIN       | pulse done
module sad_load_ctrl #(
   parameter int WIDTH    = 8,
   parameter int BUF_SIZE = 80,
   parameter int CAND_NUM = 16,
   parameter int ADDR_W   = 12,
   parameter int SAD_W    = 16,
   localparam int IDX_W   = (CAND_NUM > 1) ? $clog2(CAND_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] ref_addr,
   input  logic [ADDR_W-1:0] cand_addr,
   input  logic [ADDR_W-1:0] cand_stride,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_rd_data,
   output logic [WIDTH-1:0]  buf_data,
   output logic              ref_wr_en,
   output logic              cand_wr_en,
   output logic              ref_buf_rst,
   output logic              cand_buf_rst,
   input  logic              ref_buf_full,
   input  logic              cand_buf_full,
   output logic              sad_start,
   input  logic              sad_done,
   input  logic [SAD_W-1:0]  sad_value,
   output logic              busy,
   output logic              done,
   output logic [SAD_W-1:0]  best_sad,
   output logic [IDX_W-1:0]  best_idx
);

   localparam int CNT_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(BUF_SIZE - 1);
   localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(CAND_NUM - 1);

   typedef enum logic [3:0] {
      IDLE, CLR_REF, LOAD_REF, WAIT_REF, CLR_CAND, LOAD_CAND,
      WAIT_CAND, SAD_GO, WAIT_SAD, UPDATE, FIN
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ref_base, cand_base, stride, rd_addr;
   logic [CNT_W-1:0]  rd_left;
   logic [IDX_W-1:0]  k;
   logic [SAD_W-1:0]  sad_q;
   logic              wr_pend, wr_ref;
   logic              kill;

   // abort only matters while a search is running; it silences every strobe
   // in the cycle it is seen and freezes the datapath registers.
   assign kill     = abort && (state != IDLE);
   assign busy     = (state != IDLE);
   assign mem_addr = rd_addr;
   assign buf_data = mem_rd_data;

   // Writes trail reads by one cycle to line up with the memory latency.
   assign ref_wr_en  = wr_pend &&  wr_ref && !kill;
   assign cand_wr_en = wr_pend && !wr_ref && !kill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      mem_rd_en    = 1'b0;
      ref_buf_rst  = 1'b0;
      cand_buf_rst = 1'b0;
      sad_start    = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE:      if (start) state_nxt = CLR_REF;
         CLR_REF: begin
            ref_buf_rst  = 1'b1;
            cand_buf_rst = 1'b1;
            state_nxt    = LOAD_REF;
         end
         LOAD_REF: begin
            mem_rd_en = 1'b1;
            if (rd_left == '0) state_nxt = WAIT_REF;
         end
         WAIT_REF:  if (ref_buf_full) state_nxt = CLR_CAND;
         CLR_CAND: begin
            cand_buf_rst = 1'b1;
            state_nxt    = LOAD_CAND;
         end
         LOAD_CAND: begin
            mem_rd_en = 1'b1;
            if (rd_left == '0) state_nxt = WAIT_CAND;
         end
         WAIT_CAND: if (cand_buf_full) state_nxt = SAD_GO;
         SAD_GO: begin
            sad_start = 1'b1;
            state_nxt = WAIT_SAD;
         end
         WAIT_SAD:  if (sad_done) state_nxt = UPDATE;
         UPDATE:    state_nxt = (k == K_LAST) ? FIN : CLR_CAND;
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
      if (kill) begin
         state_nxt    = IDLE;
         mem_rd_en    = 1'b0;
         ref_buf_rst  = 1'b0;
         cand_buf_rst = 1'b0;
         sad_start    = 1'b0;
         done         = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_base  <= '0;
         cand_base <= '0;
         stride    <= '0;
         rd_addr   <= '0;
         rd_left   <= '0;
         k         <= '0;
         sad_q     <= '0;
         best_sad  <= '1;
         best_idx  <= '0;
         wr_pend   <= 1'b0;
         wr_ref    <= 1'b0;
      end else begin
         wr_pend <= mem_rd_en;
         wr_ref  <= (state == LOAD_REF);
         if (!kill) begin
            case (state)
               IDLE: if (start) begin
                  ref_base  <= ref_addr;
                  cand_base <= cand_addr;
                  stride    <= cand_stride;
                  best_sad  <= '1;
                  best_idx  <= '0;
                  k         <= '0;
               end
               CLR_REF: begin
                  rd_addr <= ref_base;
                  rd_left <= LOAD_LAST;
               end
               CLR_CAND: begin
                  rd_addr <= cand_base;
                  rd_left <= LOAD_LAST;
               end
               LOAD_REF, LOAD_CAND: begin
                  rd_addr <= rd_addr + 1'b1;
                  rd_left <= rd_left - 1'b1;
               end
               WAIT_SAD: if (sad_done) sad_q <= sad_value;
               UPDATE: begin
                  // strict compare: on a tie the earlier candidate stays
                  if (sad_q < best_sad) begin
                     best_sad <= sad_q;
                     best_idx <= k;
                  end
                  if (k != K_LAST) begin
                     k         <= k + 1'b1;
                     cand_base <= cand_base + stride;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sad_load_ctrl.sv
// tb_sad_load_ctrl
// Bench for sad_load_ctrl: memory, serial-buffer and SAD-unit models around
// the DUT, an address/write scoreboard filled when a search is launched, a
// table of full searches and hand sequences for start-while-busy, abort and
// asynchronous reset.
module tb_sad_load_ctrl;
   localparam int WIDTH = 8, BUF_SIZE = 80, CAND_NUM = 16, ADDR_W = 12;
   localparam int SAD_W = 16, IDX_W = 4;

   logic              clk, rst, start, abort;
   logic [ADDR_W-1:0] ref_addr, cand_addr, cand_stride;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_rd_data;
   logic [WIDTH-1:0]  buf_data;
   logic              ref_wr_en, cand_wr_en, ref_buf_rst, cand_buf_rst;
   logic              ref_buf_full, cand_buf_full;
   logic              sad_start, sad_done;
   logic [SAD_W-1:0]  sad_value;
   logic              busy, done;
   logic [SAD_W-1:0]  best_sad;
   logic [IDX_W-1:0]  best_idx;

   sad_load_ctrl #(
      .WIDTH(WIDTH), .BUF_SIZE(BUF_SIZE), .CAND_NUM(CAND_NUM),
      .ADDR_W(ADDR_W), .SAD_W(SAD_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .ref_addr(ref_addr), .cand_addr(cand_addr), .cand_stride(cand_stride),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .buf_data(buf_data), .ref_wr_en(ref_wr_en), .cand_wr_en(cand_wr_en),
      .ref_buf_rst(ref_buf_rst), .cand_buf_rst(cand_buf_rst),
      .ref_buf_full(ref_buf_full), .cand_buf_full(cand_buf_full),
      .sad_start(sad_start), .sad_done(sad_done), .sad_value(sad_value),
      .busy(busy), .done(done), .best_sad(best_sad), .best_idx(best_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       is_ref;
      logic [7:0] data;
   } wr_exp_t;

   typedef struct {
      logic [11:0] r, c, s;
      int          mode;
      logic [15:0] esad;
      logic [3:0]  eidx;
      bit          wrap;
      logic [11:0] ec1;
   } vec_t;

   logic [11:0] addr_q[$];
   wr_exp_t     wr_q[$];
   int          rd_idx, done_cnt, sad_k, sad_pend_k, sad_cnt, sad_mode;
   int          ref_cnt, cand_cnt;
   bit          spurious_en, rd_seen, track_en;
   logic [11:0] cand1_addr;
   vec_t        vecs[4];

   assign ref_buf_full  = (ref_cnt >= BUF_SIZE);
   assign cand_buf_full = (cand_cnt >= BUF_SIZE);

   function automatic logic [7:0] mem_val(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction

   function automatic logic [15:0] sad_of(input int mode, input int k);
      case (mode)
         0:       return 16'(500 - 10 * k);
         1:       return 16'd200;
         2:       return (k == 5 || k == 9) ? 16'd30 : 16'(100 + k);
         default: return 16'hFFFF;
      endcase
   endfunction

   // memory: one-cycle read latency
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_val(mem_addr);

   // monitor, scoreboard, buffer model and SAD responder (sampled mid-cycle)
   always @(negedge clk) begin
      if (!rst) begin
         ref_cnt  = 0;
         cand_cnt = 0;
         sad_cnt  = 0;
         sad_done = 1'b0;
      end else begin
         sad_done = 1'b0;
         if (done) done_cnt++;
         if (ref_wr_en || cand_wr_en) begin
            if (track_en) begin
               if (wr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got write, expected none");
               end else begin
                  wr_exp_t e;
                  e = wr_q.pop_front();
                  check("wr_target_ref", 32'(ref_wr_en), 32'(e.is_ref));
                  check("wr_target_cand", 32'(cand_wr_en), 32'(!e.is_ref));
                  check("buf_data", 32'(buf_data), 32'(e.data));
               end
            end
         end
         if (mem_rd_en) begin
            rd_seen = 1'b1;
            if (track_en) begin
               if (addr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_read: got addr 0x%0h, expected none", mem_addr);
               end else begin
                  logic [11:0] ea;
                  ea = addr_q.pop_front();
                  check("rd_addr", 32'(mem_addr), 32'(ea));
               end
               wr_q.push_back('{is_ref: (rd_idx < BUF_SIZE), data: mem_val(mem_addr)});
               if (rd_idx == 2 * BUF_SIZE) cand1_addr = mem_addr;
               // sad_done outside WAIT_SAD must be ignored
               if (spurious_en && (rd_idx % BUF_SIZE) == 40) begin
                  sad_done  = 1'b1;
                  sad_value = 16'd0;
               end
               rd_idx++;
            end
         end
         if (ref_buf_rst)  ref_cnt = 0;
         if (cand_buf_rst) cand_cnt = 0;
         if (ref_wr_en)    ref_cnt++;
         if (cand_wr_en)   cand_cnt++;
         if (sad_cnt > 0) begin
            sad_cnt--;
            if (sad_cnt == 0) begin
               sad_done  = 1'b1;
               sad_value = sad_of(sad_mode, sad_pend_k);
            end
         end
         if (sad_start) begin
            sad_cnt    = 3;
            sad_pend_k = sad_k;
            sad_k++;
         end
      end
   end

   task automatic start_search(input logic [11:0] r, input logic [11:0] c,
                               input logic [11:0] s, input int mode);
      logic [11:0] base;
      @(posedge clk); #1;
      addr_q.delete();
      wr_q.delete();
      rd_idx = 0; sad_k = 0; done_cnt = 0; sad_mode = mode;
      track_en = 1'b1; spurious_en = (mode == 1);
      for (int i = 0; i < BUF_SIZE; i++) addr_q.push_back(r + 12'(i));
      base = c;
      for (int k = 0; k < CAND_NUM; k++) begin
         for (int i = 0; i < BUF_SIZE; i++) addr_q.push_back(base + 12'(i));
         base = base + s;
      end
      ref_addr = r; cand_addr = c; cand_stride = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_search(input string name, input logic [15:0] esad,
                                input logic [3:0] eidx);
      int n = 0;
      while (done_cnt == 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      $display("%s: checking results", name);
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("best_sad", 32'(best_sad), 32'(esad));
      check("best_idx", 32'(best_idx), 32'(eidx));
      check("reads_left", 32'(addr_q.size()), 32'd0);
      check("writes_left", 32'(wr_q.size()), 32'd0);
      spurious_en = 1'b0;
   endtask

   initial begin
      int n;
      vecs[0] = '{12'h000, 12'h100, 12'h050, 0, 16'd350,  4'd15, 1'b0, 12'h000};
      vecs[1] = '{12'h000, 12'h100, 12'h050, 1, 16'd200,  4'd0,  1'b0, 12'h000};
      vecs[2] = '{12'h200, 12'hFF0, 12'h050, 2, 16'd30,   4'd5,  1'b1, 12'h040};
      vecs[3] = '{12'hFF8, 12'h800, 12'h001, 3, 16'hFFFF, 4'd0,  1'b0, 12'h000};

      rst = 1'b0; start = 1'b0; abort = 1'b0;
      ref_addr = '0; cand_addr = '0; cand_stride = '0;
      sad_value = '0; mem_rd_data = '0;
      track_en = 1'b0; spurious_en = 1'b0; rd_seen = 1'b0;
      rd_idx = 0; done_cnt = 0; sad_k = 0; sad_pend_k = 0; sad_mode = 0;
      cand1_addr = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("rst_buf_rst", 32'({ref_buf_rst, cand_buf_rst}), 32'd0);
      check("rst_sad_start", 32'(sad_start), 32'd0);
      check("rst_best_sad", 32'(best_sad), 32'hFFFF);
      check("rst_best_idx", 32'(best_idx), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      for (int v = 0; v < 4; v++) begin
         start_search(vecs[v].r, vecs[v].c, vecs[v].s, vecs[v].mode);
         finish_search($sformatf("vector %0d", v), vecs[v].esad, vecs[v].eidx);
         if (vecs[v].wrap) check("cand1_first_addr", 32'(cand1_addr), 32'(vecs[v].ec1));
      end

      // start during WAIT_SAD is ignored, including its new addresses
      start_search(12'h000, 12'h100, 12'h050, 0);
      n = 0;
      while (!sad_start && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("saw_sad_start", 32'(sad_start), 32'd1);
      @(posedge clk); #1;
      ref_addr = 12'h555; cand_addr = 12'h777; cand_stride = 12'h003; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      finish_search("restart ignored", 16'd350, 4'd15);

      // abort while loading candidate 3
      start_search(12'h000, 12'h100, 12'h050, 0);
      n = 0;
      while (rd_idx < 4 * BUF_SIZE + 10 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_k3", 32'(sad_k), 32'd3);
      @(posedge clk); #1;
      abort = 1'b1;
      track_en = 1'b0;
      @(negedge clk);
      check("abort_rd_en", 32'(mem_rd_en), 32'd0);
      check("abort_wr_en", 32'({ref_wr_en, cand_wr_en}), 32'd0);
      @(posedge clk); #1 abort = 1'b0;
      rd_seen = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (200) @(negedge clk);
      check("abort_no_reads", 32'(rd_seen), 32'd0);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_best_sad", 32'(best_sad), 32'd480);
      check("abort_best_idx", 32'(best_idx), 32'd2);

      // asynchronous reset during LOAD_REF
      start_search(12'h000, 12'h100, 12'h050, 0);
      n = 0;
      while (rd_idx < 20 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_reached_load", 32'(mem_rd_en), 32'd1);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      check("arst_rd_en", 32'(mem_rd_en), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_wr_en", 32'({ref_wr_en, cand_wr_en}), 32'd0);
      check("arst_best", 32'({best_sad, 12'h0, best_idx}), 32'hFFFF0000);
      track_en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      rd_seen = 1'b0;
      done_cnt = 0;
      repeat (200) @(negedge clk);
      check("arst_no_resume", 32'(rd_seen), 32'd0);
      check("arst_idle", 32'({busy, done_cnt[0]}), 32'd0);

      start_search(vecs[0].r, vecs[0].c, vecs[0].s, vecs[0].mode);
      finish_search("after reset", vecs[0].esad, vecs[0].eidx);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sad_load_ctrl.md
SAD_LOAD_CTRL -- requirements
Module: sad_load_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 8, pixel width.
- BUF_SIZE, 80, pixels per block.
- CAND_NUM, 16, candidate blocks per search.
- ADDR_W, 12, memory address width.
- SAD_W, 16, SAD result width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, search request pulse.
- abort, in, 1, cancel search.
- ref_addr, in, ADDR_W, reference block base address.
- cand_addr, in, ADDR_W, first candidate base address.
- cand_stride, in, ADDR_W, address step between candidates.
- mem_rd_en, out, 1, memory read strobe.
- mem_addr, out, ADDR_W, memory read address.
- mem_rd_data, in, WIDTH, read data, valid exactly 1 cycle after mem_rd_en.
- buf_data, out, WIDTH, pixel to buffers.
- ref_wr_en / cand_wr_en, out, 1, write strobes to the reference / candidate serial buffers.
- ref_buf_rst / cand_buf_rst, out, 1, active-high buffer clear pulses.
- ref_buf_full / cand_buf_full, in, 1, buffer full flags.
- sad_start, out, 1, SAD unit start pulse.
- sad_done, in, 1, SAD result valid pulse.
- sad_value, in, SAD_W, SAD result.
- busy, out, 1, search in progress.
- done, out, 1, one-cycle search-complete pulse.
- best_sad, out, SAD_W, minimum SAD found.
- best_idx, out, clog2(CAND_NUM), index of minimum.

Function
REQ-003 FSM states SHALL be: IDLE, CLR_REF, LOAD_REF, WAIT_REF, CLR_CAND, LOAD_CAND, WAIT_CAND, SAD_GO, WAIT_SAD, UPDATE, FIN.
REQ-004 IDLE: start=1 SHALL latch ref_addr, cand_addr and cand_stride, set best_sad to all-ones and the candidate index k to 0, and go to CLR_REF; start in any other state SHALL be ignored.
REQ-005 CLR_REF SHALL assert ref_buf_rst and cand_buf_rst for exactly one cycle, then go to LOAD_REF.
REQ-006 LOAD_REF/LOAD_CAND SHALL assert mem_rd_en for BUF_SIZE consecutive cycles, with mem_addr = base+0 .. base+BUF_SIZE-1 (modulo 2^ADDR_W), then advance to WAIT_REF/WAIT_CAND.
REQ-007 The x_wr_en of the active buffer SHALL equal mem_rd_en delayed one cycle; buf_data SHALL equal mem_rd_data; exactly BUF_SIZE writes occur per load.
REQ-008 WAIT_REF SHALL hold until ref_buf_full=1, then go to CLR_CAND; WAIT_CAND SHALL hold until cand_buf_full=1, then go to SAD_GO.
REQ-009 CLR_CAND SHALL assert cand_buf_rst only (one cycle); the reference buffer is loaded once per search and SHALL NOT be cleared per candidate.
REQ-010 The candidate base address SHALL be latched cand_addr + k*cand_stride, accumulated by addition, modulo 2^ADDR_W.
REQ-011 SAD_GO SHALL pulse sad_start for one cycle; WAIT_SAD SHALL hold until sad_done=1 and capture sad_value.
REQ-012 UPDATE: if sad_value < best_sad (strict), best_sad/best_idx SHALL take sad_value/k; ties SHALL keep the earlier index.
REQ-013 UPDATE: if k = CAND_NUM-1, go to FIN; else k increments and the FSM returns to CLR_CAND.
REQ-014 FIN SHALL pulse done for one cycle, then return to IDLE; best_sad/best_idx SHALL hold until the next start.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE next cycle, deassert all strobes that cycle, and suppress done; best_sad/best_idx SHALL hold their partial values.
REQ-017 sad_done outside WAIT_SAD and full flags outside WAIT states SHALL be ignored.

Reset
REQ-018 rst=0 SHALL asynchronously force IDLE; all strobes, busy and done = 0; best_sad = all-ones; best_idx = 0; k = 0; latched addresses = 0.
REQ-019 Reset deassertion mid-search SHALL NOT resume; a new start is required.

Verification
REQ-020 Scenarios:
- ref_addr=0x000, cand_addr=0x100, cand_stride=0x050, SAD returns 500-10*k -> best_sad=350, best_idx=15, one done pulse.
- All SAD values = 200 -> best_idx=0 (tie rule).
- cand_addr=0xFF0, cand_stride=0x050 -> second candidate reads start at 0x040 (wrap).
- abort asserted during LOAD_CAND at k=3 -> IDLE next cycle, no done, busy=0, no further mem_rd_en.
- start pulsed during WAIT_SAD -> ignored; search completes normally.
- rst low during LOAD_REF -> all outputs immediately at reset values; no activity until next start.
